// File: rtl/spi_cmd_rx_pkg.sv
// Shared definitions for the SPI command receiver: FSM encoding, frame
// width and the idle levels the input synchronizers reset to.
package spi_cmd_rx_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_t;

  localparam int SPI_BITS = 8;

  // Levels an idle mode-0 bus presents; synchronizers start here.
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_cmd_rx_if.sv
// Bundle of the SPI pins and the controller-side byte queue handshake.
// slave is the receiver's view; master is the host/controller view.
interface spi_cmd_rx_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          spi_sclk;
  logic                          spi_cs_n;
  logic                          spi_mosi;
  logic                          spi_miso;
  logic [7:0]                    tx_byte;
  logic [7:0]                    out_byte;
  logic                          out_valid;
  logic                          next;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          frame_active;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tx_byte, next,
    output spi_miso, out_byte, out_valid, fifo_count, overflow, frame_active
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tx_byte, next,
    input  spi_miso, out_byte, out_valid, fifo_count, overflow, frame_active
  );
endinterface

// File: rtl/spi_cmd_rx_byte_fifo.sv
// Synchronous first-word-fall-through FIFO. DEPTH must be a power of two so
// the pointers wrap on their own. A pop frees the slot a same-cycle push
// into a full queue needs; a pop on an empty queue is ignored.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage write.
  // NOTE: the data array has no reset; the empty flag and head gating make
  // stale contents invisible, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign head  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave byte receiver. SPI pins are oversampled in the clk domain
// (clk >= 8x sclk), bytes are pushed into a fall-through queue for the
// controller, and the controller's status byte is shifted back on MISO.
module spi_cmd_rx
  import spi_cmd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  spi_cmd_rx_if.slave    bus
);
  localparam int                      CW       = $clog2(SPI_BITS);
  localparam logic [CW-1:0]           BIT_LAST = CW'(SPI_BITS - 1);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic [SYNC_STAGES:0]   r_primed;
  logic                   w_sclk, w_cs_n, w_mosi, w_primed;
  logic                   w_sclk_rise, w_sclk_fall, w_cs_fall;

  state_t                 r_state;
  logic [CW-1:0]          r_bit_ctr;
  // Only seven bits are held; the eighth comes straight from mosi at push.
  logic [SPI_BITS-2:0]    r_rx_shift;
  logic [SPI_BITS-1:0]    r_tx_shift;
  logic                   r_reload_pending;
  logic                   r_push;
  logic [SPI_BITS-1:0]    r_push_data;
  logic                   r_miso;
  logic                   r_frame_active;
  logic                   r_overflow;
  logic                   w_full, w_empty;

  // Synchronize the async SPI pins and keep a delayed copy for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      r_cs_sync   <= {SYNC_STAGES{CS_N_IDLE}};
      r_mosi_sync <= {SYNC_STAGES{MOSI_IDLE}};
      r_sclk_d    <= SCLK_IDLE;
      r_cs_d      <= CS_N_IDLE;
      r_primed    <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
      r_primed    <= {r_primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk &  r_sclk_d;
  assign w_cs_fall   = ~w_cs_n &  r_cs_d;
  // The synchronizers come out of reset holding idle levels, not pin samples.
  // Until real samples reach the delayed copy, a low cs_n would look like a
  // fresh falling edge and start a frame mid-byte, so WAIT_IDLE holds off.
  assign w_primed    = r_primed[SYNC_STAGES];

  // Frame FSM: bit counting, receive/transmit shifting and push generation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_WAIT_IDLE;
      r_bit_ctr        <= '0;
      r_rx_shift       <= '0;
      r_tx_shift       <= '0;
      r_reload_pending <= 1'b0;
      r_push           <= 1'b0;
      r_push_data      <= '0;
      r_miso           <= 1'b0;
      r_frame_active   <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_miso <= (r_state == ST_ACTIVE) ? r_tx_shift[SPI_BITS-1] : 1'b0;
      case (r_state)
        ST_WAIT_IDLE: begin
          if (w_primed && w_cs_n) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state          <= ST_ACTIVE;
            r_frame_active   <= 1'b1;
            r_bit_ctr        <= '0;
            r_tx_shift       <= bus.tx_byte;
            r_reload_pending <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_n) begin
            r_state          <= ST_IDLE;
            r_frame_active   <= 1'b0;
            r_bit_ctr        <= '0;
            r_reload_pending <= 1'b0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[SPI_BITS-3:0], w_mosi};
            if (r_bit_ctr == BIT_LAST) begin
              r_push           <= 1'b1;
              r_push_data      <= {r_rx_shift, w_mosi};
              r_bit_ctr        <= '0;
              r_reload_pending <= 1'b1;
            end else begin
              r_bit_ctr <= r_bit_ctr + 1'b1;
            end
          end else if (w_sclk_fall) begin
            if (r_reload_pending) begin
              r_tx_shift       <= bus.tx_byte;
              r_reload_pending <= 1'b0;
            end else begin
              r_tx_shift <= {r_tx_shift[SPI_BITS-2:0], 1'b0};
            end
          end
        end
        default: begin
          r_state        <= ST_WAIT_IDLE;
          r_frame_active <= 1'b0;
        end
      endcase
    end
  end

  // Sticky drop flag: a push into a full queue with no pop to make room.
  always_ff @(posedge clk) begin
    if (reset)                                r_overflow <= 1'b0;
    else if (r_push && w_full && !bus.next)   r_overflow <= 1'b1;
  end

  byte_fifo #(
    .WIDTH (SPI_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_push),
    .push_data (r_push_data),
    .pop       (bus.next),
    .head      (bus.out_byte),
    .count     (bus.fifo_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign bus.out_valid    = ~w_empty;
  assign bus.overflow     = r_overflow;
  assign bus.spi_miso     = r_miso;
  assign bus.frame_active = r_frame_active;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: an SPI mode-0 host model drives frames,
// the controller side pops bytes, and each scenario checks its own results.
module tb_spi_cmd_rx;
  localparam int FIFO_DEPTH  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 80;   // sclk half period: 8 clk of 10 ns

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  spi_cmd_rx_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  spi_cmd_rx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1);
  end

  // All stimulus changes land 1 ns after a rising clk edge.
  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    bus.spi_cs_n = 1'b1;
    #(2*HALF);
  endtask

  // Shift n bits MSB first; captures MISO just before each rising sclk.
  // With pop_at_end, next is pulsed in the cycle the last bit gets pushed.
  task automatic send_bits(input logic [7:0] b, input int n,
                           input bit pop_at_end, output logic [7:0] miso_bits);
    miso_bits = '0;
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = b[7-i];
      #HALF;
      miso_bits = {miso_bits[6:0], bus.spi_miso};
      bus.spi_sclk = 1'b1;
      if (pop_at_end && i == n-1) begin
        repeat (3) @(posedge clk);
        #1 bus.next = 1'b1;
        @(posedge clk);
        #1 bus.next = 1'b0;
        #(HALF-40);
      end else begin
        #HALF;
      end
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] dummy;
    send_bits(b, 8, 1'b0, dummy);
  endtask

  task automatic pop_once();
    @(posedge clk); #1 bus.next = 1'b1;
    @(posedge clk); #1 bus.next = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    tests_run++; if (bus.out_byte !== 8'h00) begin tests_failed++; $display("FAIL reset_out_byte got=%h exp=00", bus.out_byte); end
    tests_run++; if (bus.fifo_count !== 5'd0) begin tests_failed++; $display("FAIL reset_fifo_count got=%0d exp=0", bus.fifo_count); end
    tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    tests_run++; if (bus.spi_miso !== 1'b0) begin tests_failed++; $display("FAIL reset_miso got=%b exp=0", bus.spi_miso); end
    tests_run++; if (bus.frame_active !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_active got=%b exp=0", bus.frame_active); end
  endtask

  task automatic test_single_byte();
    logic [7:0] m;
    bit         seen = 1'b0;
    @(posedge clk); #1;
    cs_low();
    tests_run++; if (bus.frame_active !== 1'b1) begin tests_failed++; $display("FAIL single_frame_active got=%b exp=1", bus.frame_active); end
    send_bits(8'hA5, 7, 1'b0, m);
    bus.spi_mosi = 1'b1;                 // bit 0 of 0xA5
    #HALF;
    bus.spi_sclk = 1'b1;
    for (int c = 1; c <= SYNC_STAGES + 3; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin seen = 1'b1; break; end
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL single_latency out_valid=%b exp=1 within %0d clk", bus.out_valid, SYNC_STAGES+3); end
    tests_run++; if (bus.out_byte !== 8'hA5) begin tests_failed++; $display("FAIL single_out_byte got=%h exp=a5", bus.out_byte); end
    @(posedge clk); #1;
    #HALF;
    bus.spi_sclk = 1'b0;
    cs_high();
    @(negedge clk);
    tests_run++; if (bus.fifo_count !== 5'd1) begin tests_failed++; $display("FAIL single_count got=%0d exp=1", bus.fifo_count); end
    tests_run++; if (bus.frame_active !== 1'b0) begin tests_failed++; $display("FAIL single_frame_end got=%b exp=0", bus.frame_active); end
    pop_once();
    @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_pop_valid got=%b exp=0", bus.out_valid); end
    tests_run++; if (bus.fifo_count !== 5'd0) begin tests_failed++; $display("FAIL single_pop_count got=%0d exp=0", bus.fifo_count); end
  endtask

  task automatic test_multi_byte();
    logic [7:0] exp_q [3] = '{8'h01, 8'h10, 8'h22};
    @(posedge clk); #1;
    cs_low();
    for (int i = 0; i < 3; i++) send_byte(exp_q[i]);
    cs_high();
    @(negedge clk);
    tests_run++; if (bus.fifo_count !== 5'd3) begin tests_failed++; $display("FAIL multi_count got=%0d exp=3", bus.fifo_count); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (bus.out_byte !== exp_q[i]) begin tests_failed++; $display("FAIL multi_byte%0d got=%h exp=%h", i, bus.out_byte, exp_q[i]); end
      pop_once();
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL multi_drained got=%b exp=0", bus.out_valid); end
    // A pop on an empty queue must not underflow.
    pop_once();
    @(negedge clk);
    tests_run++; if (bus.fifo_count !== 5'd0) begin tests_failed++; $display("FAIL multi_underflow count=%0d exp=0", bus.fifo_count); end
  endtask

  task automatic test_miso();
    logic [7:0] m1, m2;
    @(posedge clk); #1;
    bus.tx_byte = 8'h83;
    cs_low();
    bus.tx_byte = 8'h5A;
    send_bits(8'h00, 8, 1'b0, m1);
    send_bits(8'h00, 8, 1'b0, m2);
    cs_high();
    @(negedge clk);
    tests_run++; if (m1 !== 8'h83) begin tests_failed++; $display("FAIL miso_byte1 got=%h exp=83", m1); end
    tests_run++; if (m2 !== 8'h5A) begin tests_failed++; $display("FAIL miso_byte2 got=%h exp=5a", m2); end
    tests_run++; if (bus.spi_miso !== 1'b0) begin tests_failed++; $display("FAIL miso_idle got=%b exp=0", bus.spi_miso); end
    bus.tx_byte = 8'h00;
    do_reset();
  endtask

  task automatic test_overflow();
    logic [7:0] m;
    @(posedge clk); #1;
    cs_low();
    for (int i = 0; i < FIFO_DEPTH; i++) send_byte(8'h40 + 8'(i));
    @(negedge clk);
    tests_run++; if (bus.fifo_count !== 5'd16) begin tests_failed++; $display("FAIL ovf_full_count got=%0d exp=16", bus.fifo_count); end
    tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_full_flag got=%b exp=0", bus.overflow); end
    tests_run++; if (bus.out_byte !== 8'h40) begin tests_failed++; $display("FAIL ovf_head got=%h exp=40", bus.out_byte); end
    @(posedge clk); #1;
    send_bits(8'hB7, 8, 1'b1, m);        // push and pop in the same cycle
    @(negedge clk);
    tests_run++; if (bus.fifo_count !== 5'd16) begin tests_failed++; $display("FAIL ovf_simul_count got=%0d exp=16", bus.fifo_count); end
    tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_simul_flag got=%b exp=0", bus.overflow); end
    @(posedge clk); #1;
    send_byte(8'hEE);                    // no room: dropped
    cs_high();
    @(negedge clk);
    tests_run++; if (bus.fifo_count !== 5'd16) begin tests_failed++; $display("FAIL ovf_drop_count got=%0d exp=16", bus.fifo_count); end
    tests_run++; if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_drop_flag got=%b exp=1", bus.overflow); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      logic [7:0] e;
      e = (i < FIFO_DEPTH-1) ? 8'h41 + 8'(i) : 8'hB7;
      @(negedge clk);
      tests_run++; if (bus.out_byte !== e) begin tests_failed++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, bus.out_byte, e); end
      pop_once();
    end
    @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_drained got=%b exp=0", bus.out_valid); end
    tests_run++; if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    do_reset();
  endtask

  task automatic test_partial_frame();
    logic [7:0] m;
    @(posedge clk); #1;
    cs_low();
    send_bits(8'hFF, 5, 1'b0, m);
    cs_high();
    cs_low();
    send_byte(8'h3C);
    cs_high();
    @(negedge clk);
    tests_run++; if (bus.fifo_count !== 5'd1) begin tests_failed++; $display("FAIL partial_count got=%0d exp=1", bus.fifo_count); end
    tests_run++; if (bus.out_byte !== 8'h3C) begin tests_failed++; $display("FAIL partial_byte got=%h exp=3c", bus.out_byte); end
    pop_once();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] m;
    @(posedge clk); #1;
    cs_low();
    send_bits(8'hAA, 3, 1'b0, m);
    do_reset();                          // cs_n still low
    send_bits(8'h55, 8, 1'b0, m);
    send_bits(8'h0F, 8, 1'b0, m);
    @(negedge clk);
    tests_run++; if (bus.fifo_count !== 5'd0) begin tests_failed++; $display("FAIL midrst_count got=%0d exp=0", bus.fifo_count); end
    tests_run++; if (bus.frame_active !== 1'b0) begin tests_failed++; $display("FAIL midrst_active got=%b exp=0", bus.frame_active); end
    @(posedge clk); #1;
    cs_high();
    cs_low();
    send_byte(8'hC3);
    cs_high();
    @(negedge clk);
    tests_run++; if (bus.fifo_count !== 5'd1) begin tests_failed++; $display("FAIL midrst_resume_count got=%0d exp=1", bus.fifo_count); end
    tests_run++; if (bus.out_byte !== 8'hC3) begin tests_failed++; $display("FAIL midrst_resume_byte got=%h exp=c3", bus.out_byte); end
  endtask

  initial begin
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_byte  = 8'h00;
    bus.next     = 1'b0;
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_miso();
    test_overflow();
    test_partial_frame();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
